// File: rtl/spi_sensor_sequencer_if.sv
// Register port between the sensor sequencer (master) and the SPI peripheral (slave).
interface spi_sensor_sequencer_if #(
    parameter int unsigned N = 32
);
    logic         wr_o;
    logic         reg_sel_o;
    logic [N-1:0] addr_o;
    logic [N-1:0] wdata_o;
    logic [N-1:0] rd_data_i;

    modport master (output wr_o, reg_sel_o, addr_o, wdata_o, input rd_data_i);
    modport slave  (input wr_o, reg_sel_o, addr_o, wdata_o, output rd_data_i);
endinterface

// File: rtl/spi_sensor_sequencer.sv
// SPI sensor sequencer: launches an NBYTES transfer, polls for completion, reads the
// received bytes from data RAM and assembles them into one sample word (byte 0 in MSBs).
// Optional macro AUTO_SAMPLE_EN adds a free-running PERIOD counter that issues start pulses.
module spi_sensor_sequencer #(
    parameter int unsigned N       = 32,
    parameter int unsigned NBYTES  = 2,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned PERIOD  = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic [8*NBYTES-1:0]   sample_o,
    output logic                  sample_valid_o,
    output logic                  err_o,
    spi_sensor_sequencer_if.master bus
);

    localparam int unsigned SW = 8 * NBYTES;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned LW = 2;
    localparam int unsigned KW = 2;
    localparam logic [N-1:0] CTRL_WORD = N'(((NBYTES - 1) << 4) | 5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_BUSY,
        S_READ,
        S_DONE,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [SW-1:0]   sample_d;
    logic            busy_d, valid_d, err_d, wr_d, reg_sel_d;
    logic [N-1:0]    addr_d, wdata_d;
    logic            start_req;
    logic            unused_c;

    // Upper read-data bits carry nothing the sequencer needs.
    assign unused_c = ^{bus.rd_data_i[N-1:8], 32'(PERIOD)};

`ifdef AUTO_SAMPLE_EN
    localparam int unsigned PW = $clog2(PERIOD);
    logic [PW-1:0] per_q;
    logic          auto_pulse_c;

    assign auto_pulse_c = (per_q == PW'(PERIOD - 1));
    assign start_req    = start_i | auto_pulse_c;

    // Free-running sample interval counter; a pulse landing while busy is simply lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_q <= '0;
        end else if (auto_pulse_c) begin
            per_q <= '0;
        end else begin
            per_q <= per_q + PW'(1);
        end
    end
`else
    assign start_req = start_i;
`endif

    // Next-state and next-output logic; outputs are registered so they track the state.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        k_d       = k_q;
        tmo_d     = tmo_q;
        shreg_d   = shreg_q;
        sample_d  = sample_o;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        wr_d      = 1'b0;
        reg_sel_d = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_LAUNCH;
                    wr_d    = 1'b1;
                    wdata_d = CTRL_WORD;
                end
            end
            S_LAUNCH: begin
                state_d = S_SETTLE;
                lat_d   = '0;
            end
            S_SETTLE: begin
                if (lat_q == LW'(RD_LAT)) begin
                    state_d = S_BUSY;
                    tmo_d   = '0;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_BUSY: begin
                if (!bus.rd_data_i[0]) begin
                    state_d   = S_READ;
                    k_d       = '0;
                    lat_d     = '0;
                    reg_sel_d = 1'b1;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                    wr_d    = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_READ: begin
                reg_sel_d = 1'b1;
                addr_d    = N'(k_q);
                if (lat_q == LW'(RD_LAT)) begin
                    for (int unsigned b = 0; b < NBYTES; b++) begin
                        if (k_q == KW'(b)) begin
                            shreg_d[8*(NBYTES-1-b) +: 8] = bus.rd_data_i[7:0];
                        end
                    end
                    lat_d = '0;
                    if (k_q == KW'(NBYTES - 1)) begin
                        state_d   = S_DONE;
                        reg_sel_d = 1'b0;
                        addr_d    = '0;
                        valid_d   = 1'b1;
                        sample_d  = shreg_d;
                    end else begin
                        k_d    = k_q + KW'(1);
                        addr_d = N'(k_d);
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            lat_q          <= '0;
            k_q            <= '0;
            tmo_q          <= '0;
            shreg_q        <= '0;
            busy_o         <= 1'b0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            err_o          <= 1'b0;
            bus.wr_o       <= 1'b0;
            bus.reg_sel_o  <= 1'b0;
            bus.addr_o     <= '0;
            bus.wdata_o    <= '0;
        end else begin
            state_q        <= state_d;
            lat_q          <= lat_d;
            k_q            <= k_d;
            tmo_q          <= tmo_d;
            shreg_q        <= shreg_d;
            busy_o         <= busy_d;
            sample_o       <= sample_d;
            sample_valid_o <= valid_d;
            err_o          <= err_d;
            bus.wr_o       <= wr_d;
            bus.reg_sel_o  <= reg_sel_d;
            bus.addr_o     <= addr_d;
            bus.wdata_o    <= wdata_d;
        end
    end

endmodule
